// File: rtl/t03_request_arbiter.sv
// rtl/t03_request_arbiter.sv - N-channel request arbiter onto a single Wishbone-manager command port
//
// Purpose: picks one of N_CH requesters (round-robin or fixed priority),
// latches its command, drives it to the manager, and reports completion
// (req_hit) or a bus-start timeout (req_err) back to that requester.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   en                   global enable, gates new grants only
//   req_valid/req_write  per-channel request and direction (1 = write)
//   req_addr/req_wdata   packed per-channel address / write data
//   req_sel              packed per-channel byte selects
//   req_hit/req_err      one-cycle completion / timeout pulse to the winner
//   rdata                last captured read data
//   busy_o, cpu_dat_o    manager busy and read data
//   read_i, write_i      strobes to manager
//   adr_i, cpu_dat_i     address and write data to manager
//   sel_i                byte select to manager
module t03_request_arbiter #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       en,
    input  logic [N_CH-1:0]            req_valid,
    input  logic [N_CH-1:0]            req_write,
    input  logic [N_CH*ADDR_W-1:0]     req_addr,
    input  logic [N_CH*DATA_W-1:0]     req_wdata,
    input  logic [N_CH*(DATA_W/8)-1:0] req_sel,
    output logic [N_CH-1:0]            req_hit,
    output logic [N_CH-1:0]            req_err,
    output logic [DATA_W-1:0]          rdata,
    input  logic                       busy_o,
    input  logic [DATA_W-1:0]          cpu_dat_o,
    output logic                       read_i,
    output logic                       write_i,
    output logic [ADDR_W-1:0]          adr_i,
    output logic [DATA_W-1:0]          cpu_dat_i,
    output logic [DATA_W/8-1:0]        sel_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  win;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [SEL_W-1:0]  lat_sel;
    logic              lat_write;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;

    // Winner selection. Round-robin scans the channels strictly after the
    // last winner, wrapping, so the previous winner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (RR_EN != 0) begin
            for (int k = 1; k <= N_CH; k++) begin
                int c;
                c = int'(ptr) + k;
                if (c >= N_CH) c = c - N_CH;
                if (!win_found && req_valid[c]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(c);
                end
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            ptr       <= IDX_W'(N_CH - 1);
            win       <= '0;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_sel   <= '0;
            lat_write <= 1'b0;
            rdata     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (en && win_found) begin
                        win       <= win_idx;
                        lat_addr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        lat_wdata <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                        lat_sel   <= req_sel[int'(win_idx)*SEL_W +: SEL_W];
                        lat_write <= req_write[win_idx];
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // cnt counts completed ISSUE cycles, so the strobe is
                    // held for exactly TIMEOUT cycles before aborting.
                    if (busy_o) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        cnt   <= '0;
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!busy_o) begin
                        if (!lat_write) rdata <= cpu_dat_o;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ptr   <= win;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    ptr   <= win;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign read_i    = (state == S_ISSUE) && !lat_write;
    assign write_i   = (state == S_ISSUE) && lat_write;
    assign adr_i     = lat_addr;
    assign cpu_dat_i = lat_wdata;
    assign sel_i     = lat_sel;

    // A requester that dropped req_valid mid-transaction gets no hit.
    always_comb begin
        req_hit = '0;
        req_err = '0;
        if (state == S_DONE && req_valid[win]) req_hit[win] = 1'b1;
        if (state == S_ERR) req_err[win] = 1'b1;
    end

endmodule

// File: tb/tb_t03_request_arbiter.sv
// tb/tb_t03_request_arbiter.sv - scoreboard bench for t03_request_arbiter (round-robin and fixed-priority instances)
module tb_t03_request_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*4-1:0]  req_sel;
    logic            busy = 1'b0;
    logic [DW-1:0]   cpu_dat = '0;

    logic [N-1:0]  hit_a, err_a, hit_b, err_b;
    logic [DW-1:0] rdata_a, rdata_b, dat_a, dat_b;
    logic [AW-1:0] adr_a, adr_b;
    logic [3:0]    sel_a, sel_b;
    logic          read_a, write_a, read_b, write_b;

    always #5 clk = ~clk;

    t03_request_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(1), .TIMEOUT(4)) dut_rr (
        .clk(clk), .nrst(rst_n), .en(en),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_sel(req_sel),
        .req_hit(hit_a), .req_err(err_a), .rdata(rdata_a),
        .busy_o(busy), .cpu_dat_o(cpu_dat),
        .read_i(read_a), .write_i(write_a), .adr_i(adr_a), .cpu_dat_i(dat_a), .sel_i(sel_a)
    );

    t03_request_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(0), .TIMEOUT(4)) dut_fp (
        .clk(clk), .nrst(rst_n), .en(en),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_sel(req_sel),
        .req_hit(hit_b), .req_err(err_b), .rdata(rdata_b),
        .busy_o(busy), .cpu_dat_o(cpu_dat),
        .read_i(read_b), .write_i(write_b), .adr_i(adr_b), .cpu_dat_i(dat_b), .sel_i(sel_b)
    );

    typedef struct packed {
        logic [N-1:0] hit;
        logic [N-1:0] err;
        logic [31:0]  rd;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_chk = 0;
    int n_err = 0;
    int done_a = 0;
    int rd_cyc = 0;
    int wr_cyc = 0;
    logic [AW-1:0] last_adr = '0;
    logic [DW-1:0] last_dat = '0;
    logic [3:0]    last_sel = '0;

    int rise = 2;
    int hold = 3;
    logic [DW-1:0] rd_val = '0;
    int scnt = 0;
    int hcnt = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_txn(input int cha, input int chb, input bit is_err, input logic [31:0] rd);
        exp_t e;
        e.hit = '0; e.err = '0; e.rd = rd;
        if (is_err) e.err[cha] = 1'b1; else e.hit[cha] = 1'b1;
        qa.push_back(e);
        e.hit = '0; e.err = '0;
        if (is_err) e.err[chb] = 1'b1; else e.hit[chb] = 1'b1;
        qb.push_back(e);
    endtask

    task automatic set_req(input int ch, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] sel);
        req_write[ch]          = wr;
        req_addr[ch*AW +: AW]  = addr;
        req_wdata[ch*DW +: DW] = wd;
        req_sel[ch*4 +: 4]     = sel;
        req_valid[ch]          = 1'b1;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_a < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(done_a >= target), 64'd1);
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (!busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(busy), 64'd1);
    endtask

    task automatic clr_cnt();
        rd_cyc = 0;
        wr_cyc = 0;
    endtask

    // Wishbone manager model: raises busy after `rise` strobe cycles, holds
    // it `hold` cycles, then returns rd_val as it drops busy.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            busy = 1'b0; scnt = 0; hcnt = 0;
        end else if (busy) begin
            if (hcnt == 0) begin
                busy = 1'b0;
                cpu_dat = rd_val;
            end else begin
                hcnt = hcnt - 1;
            end
        end else if (read_a || write_a) begin
            scnt++;
            if (scnt == rise) begin
                busy = 1'b1; hcnt = hold - 1; scnt = 0;
            end
        end else begin
            scnt = 0;
        end
    end

    // Scoreboard: every hit/err pulse pops one expectation per instance.
    always @(negedge clk) begin
        exp_t e;
        if (hit_a != 0 || err_a != 0) begin
            done_a++;
            if (qa.size() == 0) check("unexp_a", 64'({hit_a, err_a}), 64'd0);
            else begin
                e = qa.pop_front();
                check("hit_a", 64'(hit_a), 64'(e.hit));
                check("err_a", 64'(err_a), 64'(e.err));
                check("rdata_a", 64'(rdata_a), 64'(e.rd));
            end
        end
        if (hit_b != 0 || err_b != 0) begin
            if (qb.size() == 0) check("unexp_b", 64'({hit_b, err_b}), 64'd0);
            else begin
                e = qb.pop_front();
                check("hit_b", 64'(hit_b), 64'(e.hit));
                check("err_b", 64'(err_b), 64'(e.err));
                check("rdata_b", 64'(rdata_b), 64'(e.rd));
            end
        end
        if (read_a) begin rd_cyc++; last_adr = adr_a; end
        if (write_a) begin wr_cyc++; last_dat = dat_a; last_sel = sel_a; end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", 64'(read_a), 64'd0);
        check("rst_write", 64'(write_a), 64'd0);
        check("rst_hit", 64'({hit_a, err_a}), 64'd0);
        check("rst_rdata", 64'(rdata_a), 64'd0);
        check("rst_adr", 64'(adr_a), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single read on ch0
        clr_cnt(); rd_val = 32'hDEAD_BEEF;
        expect_txn(0, 0, 0, 32'hDEAD_BEEF);
        set_req(0, 0, 32'h0000_0040, 32'h0, 4'hF);
        wait_done(1, "rd_done");
        req_valid = '0;
        check("rd_strobe_cyc", 64'(rd_cyc), 64'd2);
        check("rd_adr", 64'(last_adr), 64'h40);

        // byte-select write on ch1, rdata must keep the previous read value
        clr_cnt(); rd_val = 32'h9999_9999;
        expect_txn(1, 1, 0, 32'hDEAD_BEEF);
        set_req(1, 1, 32'h0000_2000, 32'h0000_00A5, 4'b0001);
        wait_done(2, "wr_done");
        req_valid = '0;
        check("wr_strobe_cyc", 64'(wr_cyc), 64'd2);
        check("wr_no_read", 64'(rd_cyc), 64'd0);
        check("wr_dat", 64'(last_dat), 64'hA5);
        check("wr_sel", 64'(last_sel), 64'h1);

        // en low blocks the grant, raising it grants on the next edge
        clr_cnt(); en = 1'b0; rd_val = 32'h1234_5678;
        set_req(0, 0, 32'h0000_0080, 32'h0, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        check("en_block", 64'(rd_cyc + wr_cyc), 64'd0);
        expect_txn(0, 0, 0, 32'h1234_5678);
        en = 1'b1;
        @(posedge clk); #1;
        check("en_grant", 64'(read_a), 64'd1);
        wait_done(3, "en_done");
        req_valid = '0;

        // timeout on ch2, then the held request is served normally
        clr_cnt(); rise = 1000;
        expect_txn(2, 2, 1, 32'h1234_5678);
        set_req(2, 0, 32'h0000_0300, 32'h0, 4'hF);
        wait_done(4, "to_done");
        check("to_strobe_cyc", 64'(rd_cyc), 64'd4);
        rise = 2; rd_val = 32'hCAFE_F00D;
        expect_txn(2, 2, 0, 32'hCAFE_F00D);
        wait_done(5, "to_retry");
        req_valid = '0;

        // abandoned read: bus completes and rdata updates, no hit
        rd_val = 32'h0BAD_0BAD;
        set_req(1, 0, 32'h0000_0500, 32'h0, 4'hF);
        wait_busy("ab_busy");
        @(posedge clk); #1;
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
        check("ab_nohit", 64'(done_a), 64'd5);
        check("ab_rdata", 64'(rdata_a), 64'h0BAD_0BAD);

        // reset while the manager is busy
        rd_val = 32'h55AA_55AA;
        set_req(0, 0, 32'h0000_0600, 32'h0, 4'hF);
        wait_busy("rst_busy");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_strobe", 64'({read_a, write_a, read_b, write_b}), 64'd0);
        check("mid_rst_hit", 64'({hit_a, hit_b}), 64'd0);
        check("mid_rst_rdata_a", 64'(rdata_a), 64'd0);
        check("mid_rst_rdata_b", 64'(rdata_b), 64'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // contention: round-robin 0,1,2,0 and fixed priority 0,0,0,0
        rd_val = 32'h0000_0077;
        expect_txn(0, 0, 0, 32'h77);
        expect_txn(1, 0, 0, 32'h77);
        expect_txn(2, 0, 0, 32'h77);
        expect_txn(0, 0, 0, 32'h77);
        set_req(0, 0, 32'h0000_1000, 32'h0, 4'hF);
        set_req(1, 0, 32'h0000_1100, 32'h0, 4'hF);
        set_req(2, 0, 32'h0000_1200, 32'h0, 4'hF);
        wait_done(9, "rr_done");
        req_valid = '0;

        repeat (5) @(posedge clk);
        #1;
        check("qa_left", 64'(qa.size()), 64'd0);
        check("qb_left", 64'(qb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/t03_request_arbiter.md
Name: t03_request_arbiter

Overview:
- Parametrised successor to the t03 core's memory request path: arbitrates N_CH requesters (instruction fetch, data load/store, future DMA/debug ports) onto the single Wishbone-manager command interface (read_i/write_i/adr_i/cpu_dat_i/sel_i, busy_o/cpu_dat_o).
- Each requester gets a one-cycle hit pulse plus captured read data on completion.
- Adds round-robin or fixed priority, per-port byte select and a bus-start timeout with error pulse.
- Sits between the core datapath and the Wishbone manager.

Parameters:
N_CH, 2, number of requester channels (1..8); channel 0 = instruction fetch by convention
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
TIMEOUT, 15, max cycles in ISSUE waiting for busy_o rise before abort (>=1)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
en  in  1  global enable; low blocks new grants only
req_valid  in  N_CH  per-channel request, held until req_hit or req_err
req_write  in  N_CH  1 = write, 0 = read
req_addr  in  N_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_CH*DATA_W  packed write data
req_sel  in  N_CH*(DATA_W/8)  packed byte selects
req_hit  out  N_CH  one-cycle completion pulse to the granted channel
req_err  out  N_CH  one-cycle timeout pulse to the granted channel
rdata  out  DATA_W  last captured read data
busy_o  in  1  manager busy
cpu_dat_o  in  DATA_W  manager read data
read_i  out  1  read strobe to manager
write_i  out  1  write strobe to manager
adr_i  out  ADDR_W  address to manager
cpu_dat_i  out  DATA_W  write data to manager
sel_i  out  DATA_W/8  byte select to manager

Behaviour:
- Reset (nrst low, async): state IDLE; all outputs 0; rdata 0; grant pointer = N_CH-1 so channel 0 wins first; timeout counter 0. Applies immediately mid-transaction; no hit/err is issued for the aborted request.
- Clock domain: all state on posedge clk.
- IDLE: if en and any req_valid, select winner.
  - RR_EN=1: winner is the first valid channel strictly after the pointer, wrapping modulo N_CH.
  - RR_EN=0: lowest valid index wins.
  - Register winner index, addr, wdata, sel, write. Go to ISSUE next cycle. The command is latched, so later req_* changes are ignored.
- ISSUE: read_i = ~write, write_i = write, adr_i/cpu_dat_i/sel_i = latched values. Counter increments each cycle.
  - busy_o==1: go to WAIT.
  - Else if counter reaches TIMEOUT: go to ERR.
- WAIT: strobes low; adr_i/cpu_dat_i/sel_i held. On busy_o==0: capture cpu_dat_o into rdata if read (writes leave rdata unchanged), then go to DONE.
- DONE (1 cycle): req_hit[winner]=1 only if req_valid[winner] is still 1 (an abandoned request completes silently). Pointer = winner. Return to IDLE.
- ERR (1 cycle): req_err[winner]=1; rdata unchanged; pointer = winner; return to IDLE.
- Minimum latency: request visible at cycle t → strobe at t+1 → hit at t+4 with a one-cycle busy pulse. A held request can regrant at the cycle after DONE + 1 (IDLE).
- rdata is valid in the DONE cycle and holds until the next read completion.
- en low: IDLE does not grant. Any in-flight transaction finishes normally.
- Simultaneous requests: exactly one grant per transaction. Round-robin guarantees each continuously requesting channel is served within N_CH transactions.
- N_CH=1: the pointer is trivially 0; behaviour is otherwise identical.
- req_hit and req_err are never asserted together and are one-hot or zero.

Test Plan:
- Single read: ch0 valid, addr 0x0000_0040; bench raises busy_o 2 cycles after read_i, drops it 3 cycles later with cpu_dat_o=0xDEAD_BEEF → read_i high exactly 2 cycles, adr_i=0x40, req_hit=2'b01 for 1 cycle, rdata=0xDEAD_BEEF.
- Write with byte select: ch1 write addr 0x0000_2000, wdata 0x0000_00A5, sel 4'b0001 → write_i pulse, cpu_dat_i=0xA5, sel_i=0001, req_hit=2'b10, rdata unchanged.
- Round-robin contention (N_CH=3, RR_EN=1): all three held valid → grant order 0,1,2,0. With RR_EN=0 → 0,0,0.
- Timeout (TIMEOUT=4): busy_o held 0 → read_i high 4 cycles, req_err[winner] pulse, no hit; next request is served normally.
- Reset mid-WAIT: nrst low while busy_o=1 → read_i/write_i/req_hit/rdata immediately 0; after release, ch0 is granted first.
- en low with ch0 valid → no strobe for 10 cycles; raising en → grant on the next cycle. Abandoned request (drop req_valid in WAIT) → bus completes, req_hit stays 0.
